// File: rtl/phase_arb_acc.sv
`default_nettype none
// ============================================================================
// phase_arb_acc : windowed +/-1 vote accumulator over phase-arbiter channels
// with deadband up/down decision. Macro PHASE_ARB_ACC_SYNC2_EN adds a 2-flop
// synchronizer on arb_out.                                      Rev 1.0
// ============================================================================
module phase_arb_acc #(
  parameter int N_CH     = 4,
  parameter int WIN_LOG2 = 6,
  parameter int ACC_W    = $clog2(N_CH) + WIN_LOG2 + 2
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic                    en,
  input  logic [N_CH-1:0]         arb_out,
  input  logic [N_CH-1:0]         ch_mask,
  input  logic [ACC_W-2:0]        thresh,
  output logic                    dec_valid,
  output logic                    dec_up,
  output logic                    dec_dn,
  output logic signed [ACC_W-1:0] acc_out,
  output logic                    busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCUM  = 2'd1;
  localparam logic [1:0] S_REPORT = 2'd2;

  localparam logic [WIN_LOG2-1:0]     C_CNT_LAST = {WIN_LOG2{1'b1}};
  localparam logic signed [ACC_W-1:0] C_ONE      = {{(ACC_W-1){1'b0}}, 1'b1};

  logic [1:0]              r_state;
  logic [1:0]              w_state_nxt;
  logic [N_CH-1:0]         w_arb_src;
  logic [N_CH-1:0]         r_arb;
  logic [N_CH-1:0]         r_mask;
  logic signed [ACC_W-1:0] w_contrib;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_acc_nxt;
  logic [WIN_LOG2-1:0]     r_cnt;
  logic                    w_last;
  logic                    w_win_done;
  logic signed [ACC_W-1:0] w_thr;
  logic signed [ACC_W-1:0] w_thr_n;
  logic                    w_up;
  logic                    w_dn;

`ifdef PHASE_ARB_ACC_SYNC2_EN
  logic [N_CH-1:0] r_sync1;
  logic [N_CH-1:0] r_sync2;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= arb_out;
      r_sync2 <= r_sync1;
    end
  end

  assign w_arb_src = r_sync2;
`else
  assign w_arb_src = arb_out;
`endif

  // Mask is registered alongside the sample so both switch on the same boundary.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_arb  <= '0;
      r_mask <= '0;
    end else begin
      r_arb  <= w_arb_src;
      r_mask <= ch_mask;
    end
  end

  always_comb begin
    w_contrib = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (r_mask[i]) begin
        w_contrib = r_arb[i] ? (w_contrib + C_ONE) : (w_contrib - C_ONE);
      end
    end
  end

  assign w_acc_nxt  = r_acc + w_contrib;
  assign w_last     = (r_cnt == C_CNT_LAST);
  assign w_win_done = (r_state == S_ACCUM) && en && w_last;

  // Up wins the tie so a zero threshold with a zero sum never flags both.
  assign w_thr   = $signed({1'b0, thresh});
  assign w_thr_n = -w_thr;
  assign w_up    = (w_acc_nxt >= w_thr);
  assign w_dn    = !w_up && (w_acc_nxt <= w_thr_n);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   w_state_nxt = en ? S_ACCUM : S_IDLE;
      S_ACCUM: begin
        if (!en) begin
          w_state_nxt = S_IDLE;
        end else if (w_last) begin
          w_state_nxt = S_REPORT;
        end else begin
          w_state_nxt = S_ACCUM;
        end
      end
      S_REPORT: w_state_nxt = en ? S_ACCUM : S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    dec_valid = 1'b0;
    case (r_state)
      S_ACCUM:  busy      = 1'b1;
      S_REPORT: dec_valid = 1'b1;
      default: begin
        busy      = 1'b0;
        dec_valid = 1'b0;
      end
    endcase
  end

  // Counter wraps to zero on the final count, leaving a clean start for the next window.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if ((r_state == S_ACCUM) && en) begin
      r_acc <= w_acc_nxt;
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_acc <= '0;
      r_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      acc_out <= '0;
      dec_up  <= 1'b0;
      dec_dn  <= 1'b0;
    end else if (w_win_done) begin
      acc_out <= w_acc_nxt;
      dec_up  <= w_up;
      dec_dn  <= w_dn;
    end
  end

endmodule
`default_nettype wire
